// File: rtl/ex_muldiv.sv
// RV32M iterative multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_FASTPATH_EN to retire divide-by-zero and signed overflow straight from IDLE.
module ex_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        DoneE,
  output logic [31:0] ResultE
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_b;
  logic [63:0] r_acc;
  logic        r_neg, r_neg_a, r_dz, r_ovf;
  logic [5:0]  r_cnt;
  logic [31:0] r_hold;

  logic        w_start, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_dz, w_ovf;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_sum, w_rem_sh, w_diff;
  logic [63:0] w_mul_step, w_div_step, w_prod;
  logic [31:0] w_quo, w_rem, w_final;

  assign w_start = (r_state == S_IDLE) & StartE & ~FlushE;
  assign w_sgn_a = (Funct3E == 3'b001) | (Funct3E == 3'b010) |
                   (Funct3E == 3'b100) | (Funct3E == 3'b110);
  assign w_sgn_b = (Funct3E == 3'b001) | (Funct3E == 3'b100) | (Funct3E == 3'b110);
  assign w_neg_a = w_sgn_a & SrcAE[31];
  assign w_neg_b = w_sgn_b & SrcBE[31];
  assign w_abs_a = w_neg_a ? -SrcAE : SrcAE;
  assign w_abs_b = w_neg_b ? -SrcBE : SrcBE;
  assign w_dz    = Funct3E[2] & (SrcBE == '0);
  assign w_ovf   = Funct3E[2] & ~Funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == '1);

  // Multiply: {hi, lo} starts as {0, |A|}; lo bits are consumed as the multiplier.
  assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_step = {w_sum, r_acc[31:1]};

  // Divide: {rem, quo} starts as {0, |A|}; quotient bits shift in from the right.
  assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_step = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                 : {w_diff[31:0],   r_acc[30:0], 1'b1};

  assign w_prod = r_neg   ? -r_acc         : r_acc;
  assign w_quo  = r_neg   ? -r_acc[31:0]   : r_acc[31:0];
  assign w_rem  = r_neg_a ? -r_acc[63:32]  : r_acc[63:32];

  // Special cases are forced here so the fast path never depends on r_acc contents.
  always_comb begin
    w_final = '0;
    case (r_f3)
      3'b000:                 w_final = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[63:32];
      3'b100, 3'b101: begin
        if (r_dz)       w_final = '1;
        else if (r_ovf) w_final = 32'h8000_0000;
        else            w_final = w_quo;
      end
      default: begin
        if (r_dz)       w_final = r_neg_a ? -r_a : r_a;
        else if (r_ovf) w_final = '0;
        else            w_final = w_rem;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
`ifdef MULDIV_FASTPATH_EN
          w_next = (w_dz | w_ovf) ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (FlushE)              w_next = S_IDLE;
        else if (r_cnt == 6'd31) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_f3    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_neg_a <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      if (w_start) begin
        r_f3    <= Funct3E;
        r_a     <= w_abs_a;
        r_b     <= w_abs_b;
        r_acc   <= {32'd0, w_abs_a};
        r_neg   <= w_neg_a ^ w_neg_b;
        r_neg_a <= w_neg_a;
        r_dz    <= w_dz;
        r_ovf   <= w_ovf;
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= r_f3[2] ? w_div_step : w_mul_step;
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == S_DONE) r_hold <= w_final;
    end
  end

  assign StallE  = reset & (w_start | (r_state == S_CALC));
  assign DoneE   = (r_state == S_DONE);
  assign ResultE = DoneE ? w_final : r_hold;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M vectors, random ops, flush and reset cases.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  Funct3E = '0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        StallE, DoneE;
  logic [31:0] ResultE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk     (clk),
    .reset   (reset),
    .StartE  (StartE),
    .Funct3E (Funct3E),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .FlushE  (FlushE),
    .StallE  (StallE),
    .DoneE   (DoneE),
    .ResultE (ResultE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    int              ia, ib;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000;
            else return 32'(ia / ib);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return 32'(ia % ib);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Called just after a falling edge; returns in the first IDLE cycle after DONE.
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    int          lat, exp_lat;
    logic        stall_ok, fast, special;
    logic [31:0] exp_res;
    exp_res = model(f, a, b);
`ifdef MULDIV_FASTPATH_EN
    fast = 1'b1;
`else
    fast = 1'b0;
`endif
    special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = (fast && special) ? 1 : 33;
    StartE = 1'b1; Funct3E = f; SrcAE = a; SrcBE = b;
    #1;
    check({nm, ".stall_start"}, 32'(StallE), 32'd1);
    lat = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      StartE = 1'b0; Funct3E = 3'($urandom); SrcAE = $urandom; SrcBE = $urandom;
      lat++;
      #1;
      if (!DoneE && !StallE) stall_ok = 1'b0;
    end while (!DoneE && lat < 40);
    check({nm, ".latency"},    32'(lat),      32'(exp_lat));
    check({nm, ".stall_calc"}, 32'(stall_ok), 32'd1);
    check({nm, ".result"},     ResultE,       exp_res);
    check({nm, ".stall_done"}, 32'(StallE),   32'd0);
    StartE = 1'b1;  // belongs to the completing op, must be ignored
    @(negedge clk);
    StartE = 1'b0;
    #1;
    check({nm, ".done_pulse"},  32'(DoneE),  32'd0);
    check({nm, ".stall_after"}, 32'(StallE), 32'd0);
    check({nm, ".hold"},        ResultE,     exp_res);
  endtask

  logic [2:0]  d_f [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                           3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a [14] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                           32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
  logic [31:0] d_b [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                           32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic        saw_done;

    // Reset with StartE high: nothing may start.
    StartE = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; StartE = 1'b0;
    #1;
    check("reset.result", ResultE,     32'd0);
    check("reset.done",   32'(DoneE),  32'd0);
    check("reset.stall",  32'(StallE), 32'd0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      do_op($sformatf("dir%0d", i), d_f[i], d_a[i], d_b[i]);
    end

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      @(negedge clk);
      do_op($sformatf("rnd%0d", i), f, a, b);
    end

    // Flush a MUL at T+10; a DIVU started at T+11 must finish at T+44.
    @(negedge clk);
    StartE = 1'b1; Funct3E = 3'd0; SrcAE = 32'd123; SrcBE = 32'd456;
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      StartE = 1'b0;
      #1;
      if (DoneE) saw_done = 1'b1;
    end
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    check("flush.stall", 32'(StallE), 32'd0);
    check("flush.done",  32'(saw_done | DoneE), 32'd0);
    do_op("after_flush", 3'd5, 32'd9, 32'd3);

    // Make ResultE nonzero, then reset mid-DIV at T+5.
    @(negedge clk);
    do_op("pre_reset", 3'd5, 32'd100, 32'd7);
    @(negedge clk);
    StartE = 1'b1; Funct3E = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      StartE = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; StartE = 1'b1;
    @(negedge clk);
    reset = 1'b1; StartE = 1'b0;
    #1;
    check("midreset.result", ResultE,     32'd0);
    check("midreset.done",   32'(DoneE),  32'd0);
    check("midreset.stall",  32'(StallE), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (DoneE) saw_done = 1'b1;
    end
    check("midreset.no_done", 32'(saw_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
